// File: rtl/axi4_rd_master.sv
// axi4_rd_master: AXI4 read master with an FDMA-style user handshake.
// A transfer (start address + beat count) is split into INCR bursts of at most 256 beats,
// one outstanding burst at a time; R beats stream to the user with back-pressure.
// Optional build macro AXI_RD_4K_SPLIT_EN: additionally cut bursts at 4KB page boundaries.
module axi4_rd_master #(
    parameter int unsigned M_AXI_ID_WIDTH   = 1,
    parameter int unsigned M_AXI_ID         = 0,
    parameter int unsigned M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned M_AXI_DATA_WIDTH = 512
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESETN,
    // User side
    input  logic                        fdma_rareq,
    input  logic [M_AXI_ADDR_WIDTH-1:0] fdma_raddr,
    input  logic [15:0]                 fdma_rlen,
    output logic                        fdma_rbusy,
    output logic [M_AXI_DATA_WIDTH-1:0] fdma_rdata,
    output logic                        fdma_rvalid,
    input  logic                        fdma_rready,
    output logic                        fdma_rend,
    output logic [15:0]                 fdma_rcnt,
    // AXI read address channel
    output logic [M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                  M_AXI_ARLEN,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic                        M_AXI_ARLOCK,
    output logic [3:0]                  M_AXI_ARCACHE,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic [3:0]                  M_AXI_ARQOS,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    // AXI read data channel
    input  logic [M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    localparam int unsigned AXI_BYTES = M_AXI_DATA_WIDTH / 8;
    localparam int unsigned AXI_SHIFT = $clog2(AXI_BYTES);

    typedef enum logic [1:0] {StIdle, StAr, StData} state_e;

    state_e                        state_q, state_d;
    logic [M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]                   left_q, left_d;
    logic [7:0]                    arlen_q, arlen_d;
    logic [7:0]                    bcnt_q, bcnt_d;
    logic [15:0]                   rcnt_q, rcnt_d;
    logic [16:0]                   beats_nxt;
    logic [31:0]                   burst_bytes;
    logic                          beat;
`ifdef AXI_RD_4K_SPLIT_EN
    logic [16:0]                   page_beats;
`endif

    // Burst control fields are not used for control; RLAST/RRESP/RID are ignored.
    logic unused_r;
    assign unused_r = ^{M_AXI_RID, M_AXI_RRESP, M_AXI_RLAST};

    assign M_AXI_ARID    = M_AXI_ID_WIDTH'(M_AXI_ID);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'(AXI_SHIFT);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0010;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = (state_q == StAr);
    assign M_AXI_RREADY  = (state_q == StData) & fdma_rready;

    assign fdma_rbusy  = (state_q != StIdle);
    assign fdma_rdata  = M_AXI_RDATA;
    assign fdma_rvalid = (state_q == StData) & M_AXI_RVALID;
    assign beat        = fdma_rvalid & fdma_rready;
    assign fdma_rend   = beat & (left_q == 16'd1);
    assign fdma_rcnt   = rcnt_q;

    // Bytes covered by the burst just completed; 32-bit product, wraps with the address.
    assign burst_bytes = (32'(arlen_q) + 32'd1) << AXI_SHIFT;

    // Transfer sequencing: accept request, issue AR, count beats, loop or finish.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        bcnt_d  = bcnt_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            StIdle: begin
                if (fdma_rareq && (fdma_rlen != 16'd0)) begin
                    addr_d  = fdma_raddr;
                    left_d  = fdma_rlen;
                    rcnt_d  = 16'd0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (M_AXI_ARREADY) begin
                    bcnt_d  = 8'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (beat) begin
                    rcnt_d = rcnt_q + 16'd1;
                    left_d = left_q - 16'd1;
                    bcnt_d = bcnt_q + 8'd1;
                    if (bcnt_q == arlen_q) begin
                        if (left_d != 16'd0) begin
                            addr_d  = addr_q + M_AXI_ADDR_WIDTH'(burst_bytes);
                            state_d = StAr;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Size of the next burst, latched into ARLEN on every entry to the AR state.
    always_comb begin
        beats_nxt = {1'b0, left_d};
        if (beats_nxt > 17'd256) begin
            beats_nxt = 17'd256;
        end
`ifdef AXI_RD_4K_SPLIT_EN
        page_beats = 17'((13'h1000 - {1'b0, addr_d[11:0]}) >> AXI_SHIFT);
        if (beats_nxt > page_beats) begin
            beats_nxt = page_beats;
        end
`endif
        arlen_d = arlen_q;
        if ((state_d == StAr) && (state_q != StAr)) begin
            arlen_d = 8'(beats_nxt - 17'd1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q <= StIdle;
            addr_q  <= '0;
            left_q  <= '0;
            arlen_q <= '0;
            bcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            arlen_q <= arlen_d;
            bcnt_q  <= bcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_axi4_rd_master.sv
// tb_axi4_rd_master: directed + randomized bench for axi4_rd_master (DW=512, 64-byte beats).
// Honours AXI_RD_4K_SPLIT_EN in its reference burst model when the macro is defined.
module tb_axi4_rd_master;

    localparam int AW    = 32;
    localparam int DW    = 512;
    localparam int BYTES = DW / 8;
    localparam int LIMIT = 20000;

    logic          M_AXI_ACLK    = 1'b0;
    logic          M_AXI_ARESETN = 1'b0;
    logic          fdma_rareq    = 1'b0;
    logic [AW-1:0] fdma_raddr    = '0;
    logic [15:0]   fdma_rlen     = '0;
    logic          fdma_rbusy;
    logic [DW-1:0] fdma_rdata;
    logic          fdma_rvalid;
    logic          fdma_rready   = 1'b0;
    logic          fdma_rend;
    logic [15:0]   fdma_rcnt;
    logic [0:0]    M_AXI_ARID;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [7:0]    M_AXI_ARLEN;
    logic [2:0]    M_AXI_ARSIZE;
    logic [1:0]    M_AXI_ARBURST;
    logic          M_AXI_ARLOCK;
    logic [3:0]    M_AXI_ARCACHE;
    logic [2:0]    M_AXI_ARPROT;
    logic [3:0]    M_AXI_ARQOS;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [0:0]    M_AXI_RID     = '0;
    logic [DW-1:0] M_AXI_RDATA   = '0;
    logic [1:0]    M_AXI_RRESP   = '0;
    logic          M_AXI_RLAST   = 1'b0;
    logic          M_AXI_RVALID  = 1'b0;
    logic          M_AXI_RREADY;

    axi4_rd_master dut (
        .M_AXI_ACLK    (M_AXI_ACLK),
        .M_AXI_ARESETN (M_AXI_ARESETN),
        .fdma_rareq    (fdma_rareq),
        .fdma_raddr    (fdma_raddr),
        .fdma_rlen     (fdma_rlen),
        .fdma_rbusy    (fdma_rbusy),
        .fdma_rdata    (fdma_rdata),
        .fdma_rvalid   (fdma_rvalid),
        .fdma_rready   (fdma_rready),
        .fdma_rend     (fdma_rend),
        .fdma_rcnt     (fdma_rcnt),
        .M_AXI_ARID    (M_AXI_ARID),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARLOCK  (M_AXI_ARLOCK),
        .M_AXI_ARCACHE (M_AXI_ARCACHE),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARQOS   (M_AXI_ARQOS),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RID     (M_AXI_RID),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    // Slave knobs and observation state.
    int          ar_pct   = 100;
    int          rv_pct   = 100;
    bit          ar_block = 1'b0;
    int          rr_mode  = 0;
    logic [31:0] seed     = 32'h1234_5678;

    logic [AW-1:0] obs_ar_addr[$];
    logic [7:0]    obs_ar_len[$];
    logic [DW-1:0] obs_data[$];
    int            obs_rend_idx[$];
    int            rcnt_err, mirror_err, const_err, rend_stray;

    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_len[$];
    logic [AW-1:0] xfer_addr;
    int            xfer_len;

    int n_cmp = 0;
    int n_err = 0;

    // Memory contents as seen by the slave: a function of the byte address only.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = a ^ seed;
        return {(DW / 32){w ^ 32'h5A3C_0000}};
    endfunction

    // Simple AXI slave plus monitor: handshakes sampled mid-cycle, slave outputs updated after the edge.
    initial begin : slave
        bit            ar_hs, r_hs;
        logic [AW-1:0] cap_addr;
        logic [7:0]    cap_len;
        bit            sl_busy;
        logic [AW-1:0] sl_addr;
        int            sl_len, sl_idx;
        sl_busy = 1'b0;
        sl_addr = '0;
        sl_len  = 0;
        sl_idx  = 0;
        forever begin
            @(negedge M_AXI_ACLK);
            ar_hs    = M_AXI_ARESETN && M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs     = M_AXI_ARESETN && M_AXI_RVALID && M_AXI_RREADY;
            cap_addr = M_AXI_ARADDR;
            cap_len  = M_AXI_ARLEN;
            if (M_AXI_ARESETN) begin
                if (ar_hs) begin
                    obs_ar_addr.push_back(cap_addr);
                    obs_ar_len.push_back(cap_len);
                    if (M_AXI_ARSIZE !== 3'd6 || M_AXI_ARBURST !== 2'b01 || M_AXI_ARLOCK !== 1'b0 ||
                        M_AXI_ARCACHE !== 4'b0010 || M_AXI_ARPROT !== 3'd0 ||
                        M_AXI_ARQOS !== 4'd0 || M_AXI_ARID !== 1'b0)
                        const_err++;
                end
                if (M_AXI_RVALID && (M_AXI_RREADY !== fdma_rready || fdma_rvalid !== 1'b1 ||
                                     fdma_rdata !== M_AXI_RDATA))
                    mirror_err++;
                if (r_hs) begin
                    if (fdma_rcnt !== 16'(obs_data.size())) rcnt_err++;
                    if (fdma_rend === 1'b1) obs_rend_idx.push_back(obs_data.size());
                    obs_data.push_back(fdma_rdata);
                end else if (fdma_rend !== 1'b0) begin
                    rend_stray++;
                end
            end
            @(posedge M_AXI_ACLK);
            #1;
            if (!M_AXI_ARESETN) begin
                sl_busy       = 1'b0;
                M_AXI_RVALID  = 1'b0;
                M_AXI_RLAST   = 1'b0;
                M_AXI_ARREADY = 1'b0;
            end else begin
                if (r_hs) begin
                    sl_idx++;
                    if (sl_idx == sl_len) sl_busy = 1'b0;
                end
                if (ar_hs) begin
                    sl_busy = 1'b1;
                    sl_addr = cap_addr;
                    sl_len  = int'(cap_len) + 1;
                    sl_idx  = 0;
                end
                if (!(M_AXI_RVALID && !r_hs)) begin
                    if (sl_busy && $urandom_range(0, 99) < rv_pct) begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = pat(sl_addr + AW'(sl_idx * BYTES));
                        M_AXI_RLAST  = (sl_idx == sl_len - 1);
                    end else begin
                        M_AXI_RVALID = 1'b0;
                        M_AXI_RLAST  = 1'b0;
                    end
                end
                M_AXI_ARREADY = !ar_block && ($urandom_range(0, 99) < ar_pct);
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_arvalid"}, M_AXI_ARVALID, 0);
        check({tag, "_rready"}, M_AXI_RREADY, 0);
        check({tag, "_busy"}, fdma_rbusy, 0);
        check({tag, "_rvalid"}, fdma_rvalid, 0);
        check({tag, "_rend"}, fdma_rend, 0);
        check({tag, "_rcnt"}, fdma_rcnt, 0);
        check({tag, "_araddr"}, M_AXI_ARADDR, 0);
        check({tag, "_arlen"}, M_AXI_ARLEN, 0);
    endtask

    task automatic clear_obs();
        obs_ar_addr.delete();
        obs_ar_len.delete();
        obs_data.delete();
        obs_rend_idx.delete();
        rcnt_err   = 0;
        mirror_err = 0;
        const_err  = 0;
        rend_stray = 0;
    endtask

    // Reference: expected burst list from address/length arithmetic; then issue the request.
    task automatic start_xfer(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        int            left, b;
        clear_obs();
        seed      = $urandom;
        xfer_addr = addr;
        xfer_len  = len;
        exp_addr.delete();
        exp_len.delete();
        a    = addr;
        left = len;
        while (left > 0) begin
            b = (left > 256) ? 256 : left;
`ifdef AXI_RD_4K_SPLIT_EN
            if (b > (4096 - int'(a & 32'hFFF)) / BYTES) b = (4096 - int'(a & 32'hFFF)) / BYTES;
`endif
            exp_addr.push_back(a);
            exp_len.push_back(8'(b - 1));
            a    = a + AW'(b * BYTES);
            left = left - b;
        end
        fdma_raddr = addr;
        fdma_rlen  = 16'(len);
        fdma_rareq = 1'b1;
        @(posedge M_AXI_ACLK);
        #1;
        fdma_rareq = 1'b0;
    endtask

    task automatic finish_xfer(input string tag);
        int cyc, n;
        cyc = 0;
        while (!(obs_data.size() == xfer_len && fdma_rbusy === 1'b0) && cyc < LIMIT) begin
            case (rr_mode)
                0:       fdma_rready = 1'b1;
                1:       fdma_rready = ~fdma_rready;
                default: fdma_rready = 1'($urandom_range(0, 1));
            endcase
            @(posedge M_AXI_ACLK);
            #1;
            cyc++;
        end
        check({tag, "_done_in_time"}, (cyc < LIMIT), 1);
        check({tag, "_ar_count"}, obs_ar_addr.size(), exp_addr.size());
        n = (obs_ar_addr.size() < exp_addr.size()) ? obs_ar_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ar%0d_addr", tag, i), obs_ar_addr[i], exp_addr[i]);
            check($sformatf("%s_ar%0d_len", tag, i), obs_ar_len[i], exp_len[i]);
        end
        check({tag, "_beats"}, obs_data.size(), xfer_len);
        n = (obs_data.size() < xfer_len) ? obs_data.size() : xfer_len;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_data%0d", tag, i), obs_data[i], pat(xfer_addr + AW'(i * BYTES)));
        check({tag, "_rend_count"}, obs_rend_idx.size(), 1);
        if (obs_rend_idx.size() > 0) check({tag, "_rend_beat"}, obs_rend_idx[0], xfer_len - 1);
        check({tag, "_rcnt_final"}, fdma_rcnt, xfer_len);
        check({tag, "_busy_end"}, fdma_rbusy, 0);
        check({tag, "_rcnt_track"}, rcnt_err, 0);
        check({tag, "_mirror"}, mirror_err, 0);
        check({tag, "_ar_consts"}, const_err, 0);
        check({tag, "_rend_stray"}, rend_stray, 0);
    endtask

    initial begin : main
        logic [AW-1:0] a0;
        logic [7:0]    l0;
        int            bad, cyc;

        // Reset state
        repeat (2) @(posedge M_AXI_ACLK);
        #1;
        check_reset("rst");
        M_AXI_ARESETN = 1'b1;
        @(posedge M_AXI_ACLK);
        #1;

        // Single short burst, slave always ready
        rr_mode = 0; ar_pct = 100; rv_pct = 100;
        start_xfer(32'h0, 4);
        finish_xfer("t1");
`ifndef AXI_RD_4K_SPLIT_EN
        check("t1_arlen_const", (obs_ar_len.size() > 0) ? obs_ar_len[0] : 8'hxx, 3);

        // Split at 256 beats
        start_xfer(32'h0, 300);
        finish_xfer("t2");
        check("t2_ar2_addr_const", (obs_ar_addr.size() > 1) ? obs_ar_addr[1] : 'x, 32'h4000);
        check("t2_ar2_len_const", (obs_ar_len.size() > 1) ? obs_ar_len[1] : 8'hxx, 43);
`else
        // 4KB page split
        start_xfer(32'h0FC0, 4);
        finish_xfer("t5");
        check("t5_ar1_len_const", (obs_ar_len.size() > 0) ? obs_ar_len[0] : 8'hxx, 0);
        check("t5_ar2_addr_const", (obs_ar_addr.size() > 1) ? obs_ar_addr[1] : 'x, 32'h1000);
        check("t5_ar2_len_const", (obs_ar_len.size() > 1) ? obs_ar_len[1] : 8'hxx, 2);
`endif

        // User back-pressure toggling every cycle
        rr_mode = 1; fdma_rready = 1'b0;
        start_xfer(32'h0001_0000, 16);
        finish_xfer("t3");

        // ARREADY held low; request pulses while busy must be ignored
        rr_mode = 0; ar_block = 1'b1;
        start_xfer(32'h0000_2000, 8);
        cyc = 0;
        while (M_AXI_ARVALID !== 1'b1 && cyc < 10) begin
            @(posedge M_AXI_ACLK);
            #1;
            cyc++;
        end
        check("t4_arvalid_seen", M_AXI_ARVALID, 1);
        a0  = M_AXI_ARADDR;
        l0  = M_AXI_ARLEN;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            fdma_rareq = (i == 3 || i == 6);
            fdma_raddr = 32'h00AB_0000;
            fdma_rlen  = 16'd5;
            @(posedge M_AXI_ACLK);
            #1;
            if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== a0 || M_AXI_ARLEN !== l0) bad++;
        end
        fdma_rareq = 1'b0;
        check("t4_ar_stable", bad, 0);
        check("t4_araddr", a0, 32'h2000);
        ar_block = 1'b0;
        finish_xfer("t4");
        repeat (4) @(posedge M_AXI_ACLK);
        #1;
        check("t4_no_queued_req", fdma_rbusy, 0);

        // Zero-length request: no bus activity
        clear_obs();
        fdma_raddr = 32'h0000_4000; fdma_rlen = 16'd0; fdma_rareq = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge M_AXI_ACLK);
            #1;
            fdma_rareq = 1'b0;
            if (fdma_rbusy !== 1'b0 || M_AXI_ARVALID !== 1'b0) bad++;
        end
        check("t0len_idle", bad, 0);
        check("t0len_no_ar", obs_ar_addr.size(), 0);

        // Reset in the middle of a transfer, then a clean restart
        rr_mode = 0; fdma_rready = 1'b1;
        start_xfer(32'h0002_0000, 16);
        cyc = 0;
        while (obs_data.size() < 4 && cyc < 200) begin
            @(posedge M_AXI_ACLK);
            #1;
            cyc++;
        end
        check("t6_reached_beat4", (obs_data.size() >= 4), 1);
        M_AXI_ARESETN = 1'b0;
        #1;
        check_reset("t6_midrst");
        repeat (3) @(posedge M_AXI_ACLK);
        #1;
        M_AXI_ARESETN = 1'b1;
        @(posedge M_AXI_ACLK);
        #1;
        start_xfer(32'h0003_0040, 5);
        finish_xfer("t6_restart");

        // Address wrap at the top of the address space
        rr_mode = 2; ar_pct = 60; rv_pct = 70;
        start_xfer(32'hFFFF_C000, 300);
        finish_xfer("twrap");

        // Randomized transfers under random AR/R/user timing
        for (int k = 0; k < 6; k++) begin
            ar_pct = $urandom_range(30, 100);
            rv_pct = $urandom_range(30, 100);
            start_xfer($urandom & 32'hFFFF_FFC0, $urandom_range(1, 700));
            finish_xfer($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
